// File: rtl/qspi_byte_engine.sv
// Byte-level QSPI master behind a 3-bit register channel.
// Shifts one byte per TXDATA write in single, dual or quad mode.
module qspi_byte_engine #(
    parameter logic [7:0] DIV_RST = 8'd1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       qspi_if_req_vld,
    output logic       qspi_if_req_rdy,
    input  logic       qspi_if_req_read,
    input  logic [2:0] qspi_if_req_addr,
    input  logic [7:0] qspi_if_req_dat,
    output logic       qspi_if_rsp_vld,
    input  logic       qspi_if_rsp_rdy,
    output logic [7:0] qspi_if_rsp_dat,
    output logic       qspi_if_sck,
    output logic       qspi_if_csn,
    output logic       qspi_if_dq0_en,
    output logic       qspi_if_dq0_o,
    input  logic       qspi_if_dq0_i,
    output logic       qspi_if_dq1_en,
    output logic       qspi_if_dq1_o,
    input  logic       qspi_if_dq1_i,
    output logic       qspi_if_dq2_en,
    output logic       qspi_if_dq2_o,
    input  logic       qspi_if_dq2_i,
    output logic       qspi_if_dq3_en,
    output logic       qspi_if_dq3_o,
    input  logic       qspi_if_dq3_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [2:0] A_TX  = 3'd0;
    localparam logic [2:0] A_RX  = 3'd1;
    localparam logic [2:0] A_CTL = 3'd2;
    localparam logic [2:0] A_DIV = 3'd3;
    localparam logic [2:0] A_STS = 3'd4;

    logic [1:0] state_q, state_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic [7:0] div_q, div_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rxsh_q, rxsh_d;
    logic [7:0] rsp_dat_q, rsp_dat_d;
    logic       rsp_vld_q, rsp_vld_d;
    logic       sck_q, sck_d;
    logic [2:0] pls_q, pls_d;
    logic [3:0] dq_q, dq_d;

    logic       is_dual;
    logic       is_quad;
    logic       dir;
    logic       busy;
    logic       req_acc;
    logic [7:0] rd_dat;
    logic [2:0] last_pls;
    logic [3:0] grp_dq;
    logic [7:0] tx_shl;
    logic [7:0] rx_shl;
    logic [3:0] pad_en;
    logic [1:0] o23;

    assign is_dual = (ctrl_q[2:1] == 2'd1);
    assign is_quad = (ctrl_q[2:1] == 2'd2);
    assign dir     = ctrl_q[3];
    assign busy    = (state_q != ST_IDLE);

    // Only STATUS reads may slip in while a byte is on the wire.
    assign qspi_if_req_rdy = ~rsp_vld_q &
        (~busy | (qspi_if_req_read & (qspi_if_req_addr == A_STS)));
    assign req_acc = qspi_if_req_vld & qspi_if_req_rdy;

    always_comb begin
        rd_dat = 8'h00;
        case (qspi_if_req_addr)
            A_RX:    rd_dat = rx_q;
            A_CTL:   rd_dat = {4'h0, ctrl_q};
            A_DIV:   rd_dat = div_q;
            A_STS:   rd_dat = {7'h00, busy};
            default: rd_dat = 8'h00;
        endcase
    end

    always_comb begin
        grp_dq   = dq_q;
        tx_shl   = tx_q;
        rx_shl   = {rxsh_q[6:0], qspi_if_dq1_i};
        last_pls = 3'd7;
        unique case (1'b1)
            is_quad: begin
                grp_dq   = tx_q[7:4];
                tx_shl   = {tx_q[3:0], 4'h0};
                rx_shl   = {rxsh_q[3:0], qspi_if_dq3_i, qspi_if_dq2_i,
                            qspi_if_dq1_i, qspi_if_dq0_i};
                last_pls = 3'd1;
            end
            is_dual: begin
                grp_dq   = {dq_q[3:2], tx_q[7:6]};
                tx_shl   = {tx_q[5:0], 2'b00};
                rx_shl   = {rxsh_q[5:0], qspi_if_dq1_i, qspi_if_dq0_i};
                last_pls = 3'd3;
            end
            default: begin
                grp_dq   = {dq_q[3:1], tx_q[7]};
                tx_shl   = {tx_q[6:0], 1'b0};
                rx_shl   = {rxsh_q[6:0], qspi_if_dq1_i};
                last_pls = 3'd7;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rxsh_d    = rxsh_q;
        rsp_dat_d = rsp_dat_q;
        rsp_vld_d = rsp_vld_q;
        sck_d     = sck_q;
        pls_d     = pls_q;
        dq_d      = dq_q;

        if (rsp_vld_q & qspi_if_rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end

        if (req_acc) begin
            if (qspi_if_req_read) begin
                rsp_vld_d = 1'b1;
                rsp_dat_d = rd_dat;
            end else begin
                case (qspi_if_req_addr)
                    A_TX: begin
                        tx_d    = qspi_if_req_dat;
                        state_d = ST_LOAD;
                    end
                    A_CTL:   ctrl_d = qspi_if_req_dat[3:0];
                    A_DIV:   div_d  = qspi_if_req_dat;
                    default: ;
                endcase
            end
        end

        case (state_q)
            ST_LOAD: begin
                dq_d    = grp_dq;
                tx_d    = tx_shl;
                cnt_d   = 8'h00;
                pls_d   = 3'd0;
                sck_d   = 1'b0;
                rxsh_d  = 8'h00;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d = 8'h00;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rxsh_d = rx_shl;
                    end else if (pls_q == last_pls) begin
                        state_d = ST_IDLE;
                        rx_d    = rxsh_q;
                    end else begin
                        pls_d = pls_q + 3'd1;
                        dq_d  = grp_dq;
                        tx_d  = tx_shl;
                    end
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= 4'h0;
            div_q     <= DIV_RST;
            rx_q      <= 8'h00;
            cnt_q     <= 8'h00;
            tx_q      <= 8'h00;
            rxsh_q    <= 8'h00;
            rsp_dat_q <= 8'h00;
            rsp_vld_q <= 1'b0;
            sck_q     <= 1'b0;
            pls_q     <= 3'd0;
            dq_q      <= 4'h0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            div_q     <= div_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rxsh_q    <= rxsh_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_vld_q <= rsp_vld_d;
            sck_q     <= sck_d;
            pls_q     <= pls_d;
            dq_q      <= dq_d;
        end
    end

    // IO2/IO3 double as WP#/HOLD# and stay high outside quad mode.
    always_comb begin
        pad_en = 4'b1101;
        o23    = 2'b11;
        unique case (1'b1)
            is_quad: begin
                pad_en = {4{~dir}};
                o23    = dq_q[3:2];
            end
            is_dual: pad_en = {2'b11, ~dir, ~dir};
            default: ;
        endcase
    end

    assign qspi_if_rsp_vld = rsp_vld_q;
    assign qspi_if_rsp_dat = rsp_dat_q;
    assign qspi_if_sck     = sck_q;
    assign qspi_if_csn     = ~ctrl_q[0];
    assign qspi_if_dq0_en  = pad_en[0];
    assign qspi_if_dq1_en  = pad_en[1];
    assign qspi_if_dq2_en  = pad_en[2];
    assign qspi_if_dq3_en  = pad_en[3];
    assign qspi_if_dq0_o   = dq_q[0];
    assign qspi_if_dq1_o   = dq_q[1];
    assign qspi_if_dq2_o   = o23[0];
    assign qspi_if_dq3_o   = o23[1];

endmodule

// File: tb/tb_qspi_byte_engine.sv
// Self-checking bench for qspi_byte_engine with a pad loopback model.
module tb_qspi_byte_engine;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic       req_read = 1'b0;
    logic [2:0] req_addr = 3'd0;
    logic [7:0] req_dat = 8'h00;
    logic       rsp_vld;
    logic       rsp_rdy = 1'b1;
    logic [7:0] rsp_dat;
    logic       sck, csn;
    logic       dq0_en, dq0_o, dq0_i;
    logic       dq1_en, dq1_o, dq1_i;
    logic       dq2_en, dq2_o, dq2_i;
    logic       dq3_en, dq3_o, dq3_i;
    logic [3:0] drv = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    // A pad reads back its own driver when enabled, else the flash.
    assign dq0_i = dq0_en ? dq0_o : drv[0];
    assign dq1_i = dq1_en ? dq1_o : drv[1];
    assign dq2_i = dq2_en ? dq2_o : drv[2];
    assign dq3_i = dq3_en ? dq3_o : drv[3];

    qspi_byte_engine #(.DIV_RST(8'd1)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .qspi_if_req_vld (req_vld),
        .qspi_if_req_rdy (req_rdy),
        .qspi_if_req_read(req_read),
        .qspi_if_req_addr(req_addr),
        .qspi_if_req_dat (req_dat),
        .qspi_if_rsp_vld (rsp_vld),
        .qspi_if_rsp_rdy (rsp_rdy),
        .qspi_if_rsp_dat (rsp_dat),
        .qspi_if_sck     (sck),
        .qspi_if_csn     (csn),
        .qspi_if_dq0_en  (dq0_en),
        .qspi_if_dq0_o   (dq0_o),
        .qspi_if_dq0_i   (dq0_i),
        .qspi_if_dq1_en  (dq1_en),
        .qspi_if_dq1_o   (dq1_o),
        .qspi_if_dq1_i   (dq1_i),
        .qspi_if_dq2_en  (dq2_en),
        .qspi_if_dq2_o   (dq2_o),
        .qspi_if_dq2_i   (dq2_i),
        .qspi_if_dq3_en  (dq3_en),
        .qspi_if_dq3_o   (dq3_o),
        .qspi_if_dq3_i   (dq3_i)
    );

    function automatic logic [3:0] grp(input logic [7:0] v, input int b,
                                       input int k);
        logic [7:0] s;
        s = v >> (8 - b * (k + 1));
        case (b)
            1:       return {3'b000, s[0]};
            2:       return {2'b00, s[1:0]};
            default: return s[3:0];
        endcase
    endfunction

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d,
                          output int waited);
        int n;
        n = 0;
        req_vld = 1'b1;
        req_read = 1'b0;
        req_addr = a;
        req_dat = d;
        #1;
        while (!req_rdy && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (!req_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_timeout addr=%0d got rdy=0 want 1", a);
        end
        @(posedge aclk);
        #1;
        req_vld = 1'b0;
        waited = n;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
        int n;
        n = 0;
        rsp_rdy = 1'b1;
        req_vld = 1'b1;
        req_read = 1'b1;
        req_addr = a;
        #1;
        while (!req_rdy && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        @(posedge aclk);
        #1;
        req_vld = 1'b0;
        req_read = 1'b0;
        req_addr = 3'd0;
        n_cmp++;
        if (rsp_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_latency addr=%0d got vld=%b want 1", a, rsp_vld);
        end
        d = rsp_dat;
        @(posedge aclk);
        #1;
    endtask

    task automatic run_xfer(input logic [3:0] ctrl, input logic [7:0] div,
                            input logic [7:0] tx, input logic [7:0] din,
                            input string nm);
        int b, np, busy, rises, last_rise, idx, w;
        logic dirb, inp, prev;
        logic [7:0] exp_rx, got;
        logic [3:0] g_out, en_exp, o_got, en_got, mask;
        dirb = ctrl[3];
        b = (ctrl[2:1] == 2'd1) ? 2 : (ctrl[2:1] == 2'd2) ? 4 : 1;
        np = 8 / b;
        mask = (b == 1) ? 4'h1 : (b == 2) ? 4'h3 : 4'hF;
        inp = (b == 1) || dirb;
        exp_rx = inp ? din : tx;
        en_exp = (b == 1) ? 4'b1101 :
                 (b == 2) ? {2'b11, ~dirb, ~dirb} : {4{~dirb}};
        bus_wr(3'd2, {4'h0, ctrl}, w);
        bus_wr(3'd3, div, w);
        g_out = grp(din, b, 0);
        drv = (b == 1) ? {2'b00, g_out[0], 1'b0} : g_out;
        bus_wr(3'd0, tx, w);
        busy = 0;
        rises = 0;
        last_rise = 0;
        idx = 0;
        prev = sck;
        while (!req_rdy && idx < 5000) begin
            idx++;
            busy++;
            if (sck && !prev) begin
                if (rises > 0) begin
                    n_cmp++;
                    if (idx - last_rise !== 2 * (int'(div) + 1)) begin
                        n_bad++;
                        $display("FAIL %s_period got=%0d want=%0d", nm,
                                 idx - last_rise, 2 * (int'(div) + 1));
                    end
                end
                o_got = {dq3_o, dq2_o, dq1_o, dq0_o};
                en_got = {dq3_en, dq2_en, dq1_en, dq0_en};
                if (rises < np && !(b > 1 && dirb)) begin
                    g_out = grp(tx, b, rises);
                    n_cmp++;
                    if ((o_got & mask) !== g_out) begin
                        n_bad++;
                        $display("FAIL %s_dout rise=%0d got=%h want=%h", nm,
                                 rises, o_got & mask, g_out);
                    end
                end
                n_cmp++;
                if (en_got !== en_exp) begin
                    n_bad++;
                    $display("FAIL %s_en got=%b want=%b", nm, en_got, en_exp);
                end
                if (b < 4) begin
                    n_cmp++;
                    if (o_got[3:2] !== 2'b11) begin
                        n_bad++;
                        $display("FAIL %s_wp_hold got=%b want=11", nm,
                                 o_got[3:2]);
                    end
                end
                n_cmp++;
                if (csn !== ~ctrl[0]) begin
                    n_bad++;
                    $display("FAIL %s_csn got=%b want=%b", nm, csn, ~ctrl[0]);
                end
                last_rise = idx;
                rises++;
                if (rises < np) begin
                    g_out = grp(din, b, rises);
                    drv = (b == 1) ? {2'b00, g_out[0], 1'b0} : g_out;
                end
            end
            prev = sck;
            @(posedge aclk);
            #1;
        end
        n_cmp++;
        if (idx >= 5000) begin
            n_bad++;
            $display("FAIL %s_timeout got busy>=%0d want idle", nm, idx);
        end
        n_cmp++;
        if (rises !== np) begin
            n_bad++;
            $display("FAIL %s_pulses got=%0d want=%0d", nm, rises, np);
        end
        n_cmp++;
        if (busy !== 1 + 2 * np * (int'(div) + 1)) begin
            n_bad++;
            $display("FAIL %s_busy got=%0d want=%0d", nm, busy,
                     1 + 2 * np * (int'(div) + 1));
        end
        n_cmp++;
        if (sck !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_sck_idle got=%b want=0", nm, sck);
        end
        bus_rd(3'd1, got);
        n_cmp++;
        if (got !== exp_rx) begin
            n_bad++;
            $display("FAIL %s_rxdata got=%h want=%h", nm, got, exp_rx);
        end
        bus_rd(3'd4, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL %s_status_end got=%h want=00", nm, got);
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        logic [15:0] pins;
        aresetn = 1'b0;
        #12;
        pins = {sck, csn, req_rdy, rsp_vld, dq0_en, dq0_o, dq1_en, dq1_o,
                dq2_en, dq2_o, dq3_en, dq3_o, 4'h0};
        n_cmp++;
        if (pins !== 16'b0110_1000_1111_0000) begin
            n_bad++;
            $display("FAIL reset_pins got=%b want=0110100011110000", pins);
        end
        n_cmp++;
        if (rsp_dat !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rsp_dat got=%h want=00", rsp_dat);
        end
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        bus_rd(3'd4, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_status got=%h want=00", got);
        end
        bus_rd(3'd3, got);
        n_cmp++;
        if (got !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_clkdiv got=%h want=01", got);
        end
        bus_rd(3'd2, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%h want=00", got);
        end
    endtask

    task automatic test_flow();
        int w;
        logic [7:0] got;
        bus_wr(3'd2, 8'h0D, w);
        rsp_rdy = 1'b0;
        req_vld = 1'b1;
        req_read = 1'b1;
        req_addr = 3'd2;
        #1;
        @(posedge aclk);
        #1;
        req_vld = 1'b0;
        req_addr = 3'd4;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_vld !== 1'b1 || rsp_dat !== 8'h0D || req_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL flow_hold cyc=%0d got vld=%b dat=%h rdy=%b want 1 0d 0",
                         i, rsp_vld, rsp_dat, req_rdy);
            end
            @(posedge aclk);
            #1;
        end
        rsp_rdy = 1'b1;
        @(posedge aclk);
        #1;
        n_cmp++;
        if (rsp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL flow_release got vld=%b want 0", rsp_vld);
        end
        req_read = 1'b0;
        req_addr = 3'd0;
        bus_wr(3'd3, 8'd3, w);
        bus_wr(3'd2, 8'h01, w);
        bus_wr(3'd0, 8'($urandom), w);
        bus_rd(3'd4, got);
        n_cmp++;
        if (got !== 8'h01) begin
            n_bad++;
            $display("FAIL flow_status_busy got=%h want=01", got);
        end
        bus_wr(3'd2, 8'h05, w);
        n_cmp++;
        if (w !== 1 + 2 * 8 * 4 - 2) begin
            n_bad++;
            $display("FAIL flow_ctrl_stall got=%0d want=%0d", w, 1 + 2 * 8 * 4 - 2);
        end
        bus_rd(3'd2, got);
        n_cmp++;
        if (got !== 8'h05) begin
            n_bad++;
            $display("FAIL flow_ctrl_applied got=%h want=05", got);
        end
    endtask

    task automatic test_reset_abort();
        int w, rises, n;
        logic prev;
        logic [7:0] got;
        bus_wr(3'd2, 8'h01, w);
        bus_wr(3'd3, 8'd1, w);
        drv = 4'hF;
        bus_wr(3'd0, 8'($urandom), w);
        rises = 0;
        n = 0;
        prev = sck;
        while (rises < 3 && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
            if (sck && !prev) rises++;
            prev = sck;
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if (sck !== 1'b0 || csn !== 1'b1 || req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_pins got sck=%b csn=%b rdy=%b want 0 1 1",
                     sck, csn, req_rdy);
        end
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        bus_rd(3'd1, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL abort_rxdata got=%h want=00", got);
        end
        bus_wr(3'd6, 8'hFF, w);
        bus_wr(3'd5, 8'hAA, w);
        bus_rd(3'd6, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL unmapped_read got=%h want=00", got);
        end
        bus_rd(3'd3, got);
        n_cmp++;
        if (got !== 8'h01) begin
            n_bad++;
            $display("FAIL unmapped_wr_div got=%h want=01", got);
        end
        bus_rd(3'd2, got);
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL unmapped_wr_ctrl got=%h want=00", got);
        end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [7:0] dv;
        for (int i = 0; i < 10; i++) begin
            c = 4'($urandom);
            dv = 8'($urandom_range(0, 2));
            run_xfer(c, dv, 8'($urandom), 8'($urandom), "rand");
        end
    endtask

    initial begin
        test_reset();
        run_xfer(4'h1, 8'd1, 8'hA5, 8'h3C, "single");
        run_xfer(4'hD, 8'd0, 8'h00, 8'hD7, "quad_in");
        run_xfer(4'h3, 8'd0, 8'h96, 8'($urandom), "dual_out");
        run_xfer(4'h5, 8'd2, 8'h5E, 8'($urandom), "quad_out");
        test_flow();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
